// File: rtl/seg7_pkg.sv
// seg7_pkg: shared active-low 7-segment glyphs, converter FSM states and BCD sizing helper
package seg7_pkg;
  localparam logic [6:0] NUM_0 = 7'b100_0000;
  localparam logic [6:0] NUM_1 = 7'b111_1001;
  localparam logic [6:0] NUM_2 = 7'b010_0100;
  localparam logic [6:0] NUM_3 = 7'b011_0000;
  localparam logic [6:0] NUM_4 = 7'b001_1001;
  localparam logic [6:0] NUM_5 = 7'b001_0010;
  localparam logic [6:0] NUM_6 = 7'b000_0010;
  localparam logic [6:0] NUM_7 = 7'b111_1000;
  localparam logic [6:0] NUM_8 = 7'b000_0000;
  localparam logic [6:0] NUM_9 = 7'b001_0000;
  localparam logic [6:0] NUM_A = 7'b000_1000;
  localparam logic [6:0] NUM_B = 7'b000_0011;
  localparam logic [6:0] NUM_C = 7'b100_0110;
  localparam logic [6:0] NUM_D = 7'b010_0001;
  localparam logic [6:0] NUM_E = 7'b000_0110;
  localparam logic [6:0] NUM_F = 7'b000_1110;
  localparam logic [6:0] DASH  = 7'b011_1111;
  localparam logic [6:0] BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  // Decimal digits needed for a w-bit unsigned value (log10(2) ~ 0.3, plus one)
  function automatic int bcd_n(input int w);
    return (w * 3) / 10 + 1;
  endfunction

  // Decimal glyph for one BCD nibble; anything above 9 is not a digit and shows a dash
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'd0:    return NUM_0;
      4'd1:    return NUM_1;
      4'd2:    return NUM_2;
      4'd3:    return NUM_3;
      4'd4:    return NUM_4;
      4'd5:    return NUM_5;
      4'd6:    return NUM_6;
      4'd7:    return NUM_7;
      4'd8:    return NUM_8;
      4'd9:    return NUM_9;
      default: return DASH;
    endcase
  endfunction
endpackage

// File: rtl/seg_bcd_conv.sv
// seg_bcd_conv: sequential shift-add-3 binary to BCD converter with a one-deep pending slot
module seg_bcd_conv
  import seg7_pkg::*;
#(
  parameter int DATA_W = 19
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         data_vld,
  output logic                         busy,
  output logic [bcd_n(DATA_W)*4-1:0]   bcd,
  output logic                         bcd_vld
);
  localparam int BCD_N = bcd_n(DATA_W);
  localparam int CW    = $clog2(DATA_W);

  state_t              state, state_nx;
  logic [DATA_W-1:0]   bin, pend;
  logic [BCD_N*4-1:0]  bcd_adj;
  logic [CW-1:0]       cnt;
  logic                pend_vld, last, start;

  assign last  = cnt == CW'(DATA_W - 1);
  assign start = state_nx == CONV && state != CONV;

  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  // Next state: a strobe seen in LOAD chains straight into the next conversion like a pending one
  always_comb
    state_nx = state == IDLE ? (data_vld ? CONV : IDLE) :
               state == CONV ? (last ? LOAD : CONV) :
               (pend_vld || data_vld) ? CONV : IDLE;

  // Result is valid for the single cycle spent in LOAD
  always_comb bcd_vld = state == LOAD;

  // Add 3 to every nibble >= 5 so the following left shift carries correctly into the next decade
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_N; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  // Conversion datapath, busy flag and pending slot (a strobe during LOAD wins over the pending value)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      busy     <= 1'b0;
    end else begin
      busy <= state_nx != IDLE;
      if (start) begin
        bin <= data_vld ? data_in : pend;
        bcd <= '0;
        cnt <= '0;
      end else if (state == CONV) begin
        {bcd, bin} <= {bcd_adj, bin} << 1;
        cnt        <= cnt + 1'b1;
      end
      pend_vld <= state == LOAD ? 1'b0 : pend_vld | (state == CONV && data_vld);
      if (state == CONV && data_vld) pend <= data_in;
    end
endmodule

// File: rtl/seg_disp_ctrl.sv
// seg_disp_ctrl: binary value to multi-digit common-anode 7-segment display with blanking, dp and overflow
module seg_disp_ctrl
  import seg7_pkg::*;
#(
  parameter int DATA_W     = 19,
  parameter int DIGITS     = 6,
  parameter int MIN_DIGITS = 4,
  parameter int DP_POS     = 3,
  parameter int BLANK_LZ   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  data_vld,
  output logic                  busy,
  output logic                  upd,
  output logic                  ovf,
  output logic [DIGITS*7-1:0]   seg,
  output logic [DIGITS-1:0]     dp_n
);
  localparam int BCD_N = bcd_n(DATA_W);
  localparam int XN    = BCD_N > DIGITS ? BCD_N : DIGITS;

  logic [BCD_N*4-1:0]  bcd;
  logic [XN*4-1:0]     bcd_x;
  logic [DIGITS*7-1:0] seg_nx;
  logic [DIGITS-1:0]   dp_nx;
  logic                bcd_vld, ovf_nx, zero_hi;

  // The decimal point must sit on a digit that is never blanked
  if (DP_POS < DIGITS && DP_POS >= MIN_DIGITS) begin : g_dp_chk
    $error("seg_disp_ctrl: DP_POS must be below MIN_DIGITS");
  end

  seg_bcd_conv #(.DATA_W(DATA_W)) u_conv (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .data_vld (data_vld),
    .busy     (busy),
    .bcd      (bcd),
    .bcd_vld  (bcd_vld)
  );

  // Glyph selection: overflow dashes, leading-zero blanking scanned from the top digit down, dp mask
  always_comb begin
    bcd_x   = (XN*4)'(bcd);
    ovf_nx  = |(bcd_x >> (4 * DIGITS));
    zero_hi = 1'b1;
    seg_nx  = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_hi = zero_hi & (bcd_x[4*i +: 4] == 4'd0);
      seg_nx[7*i +: 7] = ovf_nx ? DASH :
                         (BLANK_LZ != 0 && i >= MIN_DIGITS && zero_hi) ? BLANK :
                         glyph(bcd_x[4*i +: 4]);
    end
    dp_nx = ovf_nx ? '1 : ~(DIGITS'(1) << DP_POS);
  end

  // Output registers: refreshed only on a finished conversion, held otherwise
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      seg  <= '1;
      dp_n <= '1;
      ovf  <= 1'b0;
      upd  <= 1'b0;
    end else begin
      upd <= bcd_vld;
      if (bcd_vld) begin
        seg  <= seg_nx;
        dp_n <= dp_nx;
        ovf  <= ovf_nx;
      end
    end
endmodule

// File: tb/tb_seg_disp_ctrl.sv
// tb_seg_disp_ctrl: table-driven and sequence checks for seg_disp_ctrl (default, 5-digit and no-blank builds)
module tb_seg_disp_ctrl;
  localparam logic [6:0] GB = 7'h7F;
  localparam logic [6:0] GD = 7'h3F;
  localparam logic [6:0] G [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                    7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    logic [18:0] d;
    logic [41:0] s6;
    logic [34:0] s5;
    logic        o5;
    logic [41:0] sn;
  } vec_t;

  logic        clk, rst, data_vld;
  logic [18:0] data_in;
  logic        busy6, upd6, ovf6, busy5, upd5, ovf5, busyn, updn, ovfn;
  logic [41:0] seg6, segn;
  logic [34:0] seg5;
  logic [5:0]  dp6, dpn;
  logic [4:0]  dp5;

  int   checks = 0, errors = 0, vi = 0, lat, blow, cnt;
  vec_t tv [8];

  seg_disp_ctrl u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_vld(data_vld),
    .busy(busy6), .upd(upd6), .ovf(ovf6), .seg(seg6), .dp_n(dp6)
  );

  seg_disp_ctrl #(.DIGITS(5)) u_d5 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_vld(data_vld),
    .busy(busy5), .upd(upd5), .ovf(ovf5), .seg(seg5), .dp_n(dp5)
  );

  seg_disp_ctrl #(.BLANK_LZ(0)) u_nb (
    .clk(clk), .rst(rst), .data_in(data_in), .data_vld(data_vld),
    .busy(busyn), .upd(updn), .ovf(ovfn), .seg(segn), .dp_n(dpn)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %0h expected %0h", nm, vi, act, exp);
    end
  endtask

  task automatic strobe(input logic [18:0] v);
    @(negedge clk);
    data_in  = v;
    data_vld = 1'b1;
    @(negedge clk);
    data_vld = 1'b0;
  endtask

  // Cycles until upd6 rises (-1 on timeout) and cycles before that with busy low
  task automatic wait_upd(output int l, output int bl);
    l  = -1;
    bl = 0;
    for (int k = 1; k <= 60 && l < 0; k++) begin
      @(negedge clk);
      if (upd6) l = k;
      else if (!busy6) bl++;
    end
  endtask

  initial begin
    tv[0] = '{19'd12345,  {GB,G[1],G[2],G[3],G[4],G[5]}, {G[1],G[2],G[3],G[4],G[5]}, 1'b0, {G[0],G[1],G[2],G[3],G[4],G[5]}};
    tv[1] = '{19'd0,      {GB,GB,G[0],G[0],G[0],G[0]},   {GB,G[0],G[0],G[0],G[0]},   1'b0, {G[0],G[0],G[0],G[0],G[0],G[0]}};
    tv[2] = '{19'd524287, {G[5],G[2],G[4],G[2],G[8],G[7]}, {5{GD}},                  1'b1, {G[5],G[2],G[4],G[2],G[8],G[7]}};
    tv[3] = '{19'd100000, {G[1],G[0],G[0],G[0],G[0],G[0]}, {5{GD}},                  1'b1, {G[1],G[0],G[0],G[0],G[0],G[0]}};
    tv[4] = '{19'd7,      {GB,GB,G[0],G[0],G[0],G[7]},   {GB,G[0],G[0],G[0],G[7]},   1'b0, {G[0],G[0],G[0],G[0],G[0],G[7]}};
    tv[5] = '{19'd99999,  {GB,G[9],G[9],G[9],G[9],G[9]}, {G[9],G[9],G[9],G[9],G[9]}, 1'b0, {G[0],G[9],G[9],G[9],G[9],G[9]}};
    tv[6] = '{19'd10203,  {GB,G[1],G[0],G[2],G[0],G[3]}, {G[1],G[0],G[2],G[0],G[3]}, 1'b0, {G[0],G[1],G[0],G[2],G[0],G[3]}};
    tv[7] = '{19'd86,     {GB,GB,G[0],G[0],G[8],G[6]},   {GB,G[0],G[0],G[8],G[6]},   1'b0, {G[0],G[0],G[0],G[0],G[8],G[6]}};
    rst      = 1'b1;
    data_in  = '0;
    data_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg", seg6, {42{1'b1}});
    chk("rst_dp", dp6, 6'b111111);
    chk("rst_ovf", ovf6, 0);
    chk("rst_busy", busy6, 0);
    chk("rst_upd", upd6, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vi = i;
      strobe(tv[i].d);
      chk("busy_start", busy6, 1);
      wait_upd(lat, blow);
      chk("latency", lat, 20);
      chk("busy_during", blow, 0);
      chk("upd5", upd5, 1);
      chk("updn", updn, 1);
      chk("seg6", seg6, tv[i].s6);
      chk("dp6", dp6, 6'b110111);
      chk("ovf6", ovf6, 0);
      chk("seg5", seg5, tv[i].s5);
      chk("dp5", dp5, tv[i].o5 ? 5'b11111 : 5'b10111);
      chk("ovf5", ovf5, tv[i].o5);
      chk("segn", segn, tv[i].sn);
      chk("dpn", dpn, 6'b110111);
      @(negedge clk);
      chk("upd_pulse", upd6, 0);
      chk("busy_end", busy6, 0);
      chk("seg_hold", seg6, tv[i].s6);
    end
    vi = 100;
    strobe(19'd111);
    repeat (3) @(negedge clk);
    strobe(19'd222);
    repeat (3) @(negedge clk);
    strobe(19'd333);
    wait_upd(lat, blow);
    chk("b2b_lat1", lat, 10);
    chk("b2b_seg1", seg6, {GB,GB,G[0],G[1],G[1],G[1]});
    wait_upd(lat, blow);
    chk("b2b_lat2", lat, 20);
    chk("b2b_busy", blow, 0);
    chk("b2b_seg2", seg6, {GB,GB,G[0],G[3],G[3],G[3]});
    cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (upd6) cnt++;
    end
    chk("b2b_no_third", cnt, 0);
    chk("b2b_idle", busy6, 0);
    vi = 101;
    strobe(19'd500);
    repeat (18) @(negedge clk);
    @(negedge clk);
    data_in  = 19'd600;
    data_vld = 1'b1;
    @(negedge clk);
    data_vld = 1'b0;
    chk("load_upd", upd6, 1);
    chk("load_seg1", seg6, {GB,GB,G[0],G[5],G[0],G[0]});
    wait_upd(lat, blow);
    chk("load_lat2", lat, 20);
    chk("load_busy", blow, 0);
    chk("load_seg2", seg6, {GB,GB,G[0],G[6],G[0],G[0]});
    vi = 102;
    strobe(19'd12345);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_seg", seg6, {42{1'b1}});
    chk("abort_dp", dp6, 6'b111111);
    chk("abort_busy", busy6, 0);
    chk("abort_upd", upd6, 0);
    chk("abort_ovf", ovf6, 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (upd6 || busy6) cnt++;
    end
    chk("abort_quiet", cnt, 0);
    strobe(19'd42);
    wait_upd(lat, blow);
    chk("post_lat", lat, 20);
    chk("post_seg", seg6, {GB,GB,G[0],G[0],G[4],G[2]});
    chk("post_dp", dp6, 6'b110111);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
